mod_n_counter: RTL and testbench
================================

# mod_n_counter

Parametrised, cascadable modulo-RADIX multi-digit counter. Next generation of the single-digit decade counter, with configurable radix and digit count, up/down counting, synchronous parallel load and a registered wrap flag. Used as the general event/time-base counter in display and timing datapaths; multiple instances chain through `c`.

## Interface
- `RADIX`, default 10: modulus of each digit; legal range 2..16.
- `DIGITS`, default 2: number of cascaded digits; legal range 1..8.
- `DW`, default derived as clog2(RADIX): bits per digit. Not overridden by users.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `d` input 1: count enable. The counter advances one step per clock edge while this is high.
- `up` input 1: direction. 1 counts up; 0 counts down.
- `load` input 1: synchronous parallel load strobe.
- `load_val` input DIGITS*DW: load value. Digit 0 occupies the LSBs.
- `q` output DIGITS*DW: count value. Digit 0 occupies the LSBs.
- `c` output 1: combinational carry/borrow out, used for cascading.
- `wrap` output 1: registered one-cycle pulse that marks a full-range wrap.

## Operation
- **Reset:** while `reset`=0, `q`=0 and `wrap`=0 immediately, independent of `clk`. `c` follows the combinational rule below, so it is 0 whenever `d`=0.
- **Priority per clock edge:** `load` > `d` > hold.
- **Load (`load`=1):**
  - `q` <= `load_val` digit-wise.
  - A digit value ≥ RADIX is clamped to RADIX-1.
  - `wrap` <= 0. `d` and `up` are ignored.
- **Count up (`d`=1, `up`=1):**
  - Digit 0 increments.
  - Digit k increments only when digits 0..k-1 all equal RADIX-1.
  - A digit at RADIX-1 that increments goes to 0.
- **Count down (`d`=1, `up`=0):**
  - Digit 0 decrements.
  - Digit k decrements only when digits 0..k-1 all equal 0.
  - A digit at 0 that decrements goes to RADIX-1.
- **Full wrap:**
  - Up: all digits RADIX-1 → all 0.
  - Down: all 0 → all RADIX-1.
  - On the clock edge where a full wrap occurs, `wrap` <= 1. On every other edge, `wrap` <= 0.
- **Carry out:** `c` = `d` & ~`load` & (`up` ? all digits = RADIX-1 : all digits = 0).
  - `c` is asserted in the same cycle as the state that will wrap.
  - Feeding `c` into the `d` of the next instance yields a correct wider counter.
- **Direction change:** legal on any cycle and takes effect on the next edge; there is no pipeline to flush.
- **Hold (`d`=0, `load`=0):** `q` is unchanged and `wrap` <= 0.

## Timing
- Latency is 1 clock from `d`/`load` sampled high to the updated `q`.
- `c` is combinational from `q`, `d`, `up` and `load`, with no register stage. The path depth is linear in DIGITS.
- `wrap` rises on the same edge that writes the wrapped `q` value and lasts exactly 1 cycle.
- **Reset deassertion:**
  - `reset` deasserts synchronously to `clk`; the integrating design guarantees this.
  - The first count occurs on the first rising edge after `reset`=1 on which `d`=1.
- **Reset mid-count:** `q` and `wrap` clear immediately. Any in-flight load or count is discarded.

## Structure
- **Shared package** `counter_pkg`, containing:
  - the clog2 function used to derive `DW`;
  - the direction constants DIR_UP=1 and DIR_DOWN=0.
- **Sub-module** `counter_digit`, one instance per digit. Each instance provides:
  - inputs: clk, reset, enable-in, up, load, load digit;
  - outputs: digit value, terminal flag (at RADIX-1 when up, at 0 when down).
- **Top level:**
  - generates the DIGITS instances;
  - ANDs the terminal flags to form each digit's enable-in;
  - forms `c` from the same AND chain;
  - registers `wrap`.

## Test plan
All scenarios use RADIX=10, DIGITS=2.

1. **Reset.** Hold `reset`=0 for 10 ns with `d`=1, then release → `q`=0x00 and `wrap`=0 throughout reset. After release, `q` counts 0x01, 0x02, … on successive edges.
2. **Up wrap and digit carry.**
   - `load_val`=0x97 with `load`=1 for 1 cycle, then `d`=1, `up`=1 → `q` goes 0x98, 0x99, 0x00, 0x01.
   - `c`=1 only while `q`=0x99.
   - `wrap`=1 only in the cycle with `q`=0x00.
   - 0x09→0x10 is separately checked to confirm the digit carry.
3. **Down wrap.** Load 0x01, then `d`=1, `up`=0 → `q` goes 0x00, 0x99, 0x98. `c`=1 only while `q`=0x00. `wrap` pulses with `q`=0x99.
4. **Load priority and clamp.** Drive `load`=1, `load_val`=0xAF, `d`=1 on the same edge → `q`=0x99 (both digits clamped), `wrap`=0, no count applied.
5. **Enable gating and hold.** Toggle `d` with the pattern 1,1,1,0,0,0,0,1,1,1,1,1 from `q`=0x00 → `q` advances only on the cycles where `d`=1 and ends at 0x08.
6. **Asynchronous reset mid-count.** Count up from 0x45 and assert `reset`=0 between clock edges → `q`=0x00 before the next edge. After release, counting resumes from 0x00.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the cascadable modulo-RADIX counter family:
// digit-width helper and direction encoding.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2, never below 1 so a RADIX of 2 still gets a 1-bit digit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_digit.sv
// One modulo-RADIX digit: load (with clamp) beats enable-in beats hold.
// The terminal flag marks the value at which this digit passes a carry/borrow on.
module counter_digit
  import counter_pkg::*;
#(
  parameter int RADIX = 10,
  parameter int DW    = clog2(RADIX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_in,
  input  logic          up,
  input  logic          load,
  input  logic [DW-1:0] load_digit,
  output logic [DW-1:0] digit,
  output logic          term
);

  localparam logic [DW-1:0] MAX_V   = DW'(RADIX - 1);
  localparam logic [DW:0]   RADIX_V = (DW + 1)'(RADIX);

  logic [DW-1:0] digit_q;
  logic [DW-1:0] digit_d;

  always_comb begin
    term = (up == DIR_UP) ? (digit_q == MAX_V) : (digit_q == '0);
  end

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      // Out-of-range load digits saturate rather than alias modulo RADIX.
      digit_d = ({1'b0, load_digit} >= RADIX_V) ? MAX_V : load_digit;
    end else if (en_in) begin
      if (up == DIR_UP) digit_d = term ? '0 : digit_q + DW'(1);
      else              digit_d = term ? MAX_V : digit_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit = digit_q;

endmodule

// File: rtl/mod_n_counter.sv
// Multi-digit modulo-RADIX up/down counter with parallel load, combinational
// cascade output c and a registered one-cycle wrap pulse.
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int RADIX  = 10,
  parameter int DIGITS = 2,
  parameter int DW     = clog2(RADIX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d,
  input  logic                 up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] q,
  output logic                 c,
  output logic                 wrap
);

  logic [DIGITS-1:0] term;
  logic [DIGITS:0]   chain;
  logic              wrap_q;
  logic              wrap_d;

  // chain[k] enables digit k: d AND every lower digit sitting at its terminal value.
  always_comb begin
    chain    = '0;
    chain[0] = d;
    for (int k = 0; k < DIGITS; k++) begin
      chain[k+1] = chain[k] & term[k];
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    counter_digit #(
      .RADIX (RADIX),
      .DW    (DW)
    ) u_digit (
      .clk        (clk),
      .reset      (reset),
      .en_in      (chain[gi]),
      .up         (up),
      .load       (load),
      .load_digit (load_val[gi*DW +: DW]),
      .digit      (q[gi*DW +: DW]),
      .term       (term[gi])
    );
  end

  assign c = chain[DIGITS] & ~load;

  // A full wrap happens exactly on the edges where the cascade output is high.
  always_comb begin
    wrap_d = c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter (RADIX=10, DIGITS=2) against an
// integer-valued reference model of the 0..99 count.
module tb_mod_n_counter;

  localparam int RADIX  = 10;
  localparam int DIGITS = 2;
  localparam int W      = 8;
  localparam int MODV   = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         d;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         c;
  logic         wrap;

  int n_checks = 0;
  int n_fail   = 0;

  int           m_cnt  = 0;
  logic         m_wrap = 1'b0;
  logic         exp_c;
  logic         c_obs;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mod_n_counter #(
    .RADIX  (RADIX),
    .DIGITS (DIGITS)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .d        (d),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .c        (c),
    .wrap     (wrap)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [W-1:0] to_q(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int clamp_load(input logic [W-1:0] lv);
    int t;
    int o;
    t = int'(lv[7:4]);
    o = int'(lv[3:0]);
    if (t > RADIX - 1) t = RADIX - 1;
    if (o > RADIX - 1) o = RADIX - 1;
    return t * RADIX + o;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1: drives inputs, samples c before the edge, advances the
  // model across the edge and returns at posedge+1 for output sampling.
  task automatic drive(input logic di, input logic ui, input logic li,
                       input logic [W-1:0] lvi);
    d = di; up = ui; load = li; load_val = lvi;
    #1;
    exp_c = di & ~li & (ui ? (m_cnt == MODV - 1) : (m_cnt == 0));
    c_obs = c;
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_wrap = 1'b0;
    end else if (li) begin
      m_cnt = clamp_load(lvi); m_wrap = 1'b0;
    end else if (di) begin
      if (ui) begin
        m_wrap = (m_cnt == MODV - 1);
        m_cnt  = (m_cnt + 1) % MODV;
      end else begin
        m_wrap = (m_cnt == 0);
        m_cnt  = (m_cnt + MODV - 1) % MODV;
      end
    end else begin
      m_wrap = 1'b0;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; d = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
    m_cnt = 0; m_wrap = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h required 00", q); end
      n_checks++;
      if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b required 0", wrap); end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      n_checks++;
      if (q !== to_q(i)) begin n_fail++; $display("FAIL reset_release_q: got %h required %h", q, to_q(i)); end
      n_checks++;
      if (c_obs !== exp_c) begin n_fail++; $display("FAIL reset_release_c: got %b required %b", c_obs, exp_c); end
    end
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] seq[4];
    seq = '{8'h98, 8'h99, 8'h00, 8'h01};
    drive(1'b0, 1'b1, 1'b1, 8'h97);
    n_checks++;
    if (q !== 8'h97) begin n_fail++; $display("FAIL up_load_q: got %h required 97", q); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      n_checks++;
      if (q !== seq[i]) begin n_fail++; $display("FAIL up_wrap_q: got %h required %h", q, seq[i]); end
      n_checks++;
      if (c_obs !== exp_c) begin n_fail++; $display("FAIL up_wrap_c: got %b required %b", c_obs, exp_c); end
      n_checks++;
      if (wrap !== m_wrap) begin n_fail++; $display("FAIL up_wrap_pulse: got %b required %b", wrap, m_wrap); end
    end
    drive(1'b0, 1'b1, 1'b1, 8'h09);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if (q !== 8'h10) begin n_fail++; $display("FAIL digit_carry_q: got %h required 10", q); end
    n_checks++;
    if (wrap !== 1'b0) begin n_fail++; $display("FAIL digit_carry_wrap: got %b required 0", wrap); end
  endtask

  task automatic test_down_wrap();
    logic [W-1:0] seq[3];
    seq = '{8'h00, 8'h99, 8'h98};
    drive(1'b0, 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (q !== seq[i]) begin n_fail++; $display("FAIL down_wrap_q: got %h required %h", q, seq[i]); end
      n_checks++;
      if (c_obs !== exp_c) begin n_fail++; $display("FAIL down_wrap_c: got %b required %b", c_obs, exp_c); end
      n_checks++;
      if (wrap !== m_wrap) begin n_fail++; $display("FAIL down_wrap_pulse: got %b required %b", wrap, m_wrap); end
    end
  endtask

  task automatic test_load_clamp();
    drive(1'b0, 1'b1, 1'b1, 8'h99);
    // Counter sits at 99 with d=1,up=1: load must still win and suppress c.
    drive(1'b1, 1'b1, 1'b1, 8'hAF);
    n_checks++;
    if (c_obs !== 1'b0) begin n_fail++; $display("FAIL load_c: got %b required 0", c_obs); end
    n_checks++;
    if (q !== 8'h99) begin n_fail++; $display("FAIL load_clamp_q: got %h required 99", q); end
    n_checks++;
    if (wrap !== 1'b0) begin n_fail++; $display("FAIL load_clamp_wrap: got %b required 0", wrap); end
    drive(1'b1, 1'b0, 1'b1, 8'h5C);
    n_checks++;
    if (q !== 8'h59) begin n_fail++; $display("FAIL load_clamp_low_q: got %h required 59", q); end
  endtask

  task automatic test_enable_gating();
    logic pat[12];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) begin
      drive(pat[i], 1'b1, 1'b0, 8'h00);
      n_checks++;
      if (q !== to_q(m_cnt)) begin n_fail++; $display("FAIL gating_q: got %h required %h", q, to_q(m_cnt)); end
    end
    n_checks++;
    if (q !== 8'h08) begin n_fail++; $display("FAIL gating_final_q: got %h required 08", q); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b1, 8'h45);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if (q !== 8'h47) begin n_fail++; $display("FAIL async_pre_q: got %h required 47", q); end
    #2;
    rst_n = 1'b0;
    m_cnt = 0; m_wrap = 1'b0;
    #1;
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL async_reset_q: got %h required 00", q); end
    @(posedge clk); #1;
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL async_hold_q: got %h required 00", q); end
    rst_n = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      n_checks++;
      if (q !== to_q(i)) begin n_fail++; $display("FAIL async_resume_q: got %h required %h", q, to_q(i)); end
    end
  endtask

  task automatic test_random();
    logic         rd;
    logic         ru;
    logic         rl;
    logic [W-1:0] rlv;
    logic [W-1:0] e;
    for (int i = 0; i < 400; i++) begin
      rd  = ($urandom_range(0, 3) != 0);
      ru  = 1'($urandom_range(0, 1));
      rl  = ($urandom_range(0, 15) == 0);
      rlv = 8'($urandom_range(0, 255));
      drive(rd, ru, rl, rlv);
      exp_q.push_back(to_q(m_cnt));
      e = exp_q.pop_front();
      n_checks++;
      if (q !== e) begin n_fail++; $display("FAIL random_q: got %h required %h", q, e); end
      n_checks++;
      if (c_obs !== exp_c) begin n_fail++; $display("FAIL random_c: got %b required %b", c_obs, exp_c); end
      n_checks++;
      if (wrap !== m_wrap) begin n_fail++; $display("FAIL random_wrap: got %b required %b", wrap, m_wrap); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_enable_gating();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
